// File: rtl/ram_module.sv
// ---------------------------------------------------------------------------
// ram_module
//   Single-port synchronous 32-bit data RAM with byte addressing.
//   - The word index is addr[ADDR_WIDTH-1:2]. The low two address bits are
//     ignored, so a misaligned access reaches the word that contains it.
//   - Read data is registered with one-cycle latency. Writes are write-first:
//     on a write, data_out takes the value being written.
//   - ce=0, an out-of-range word index, or rst clears the read register.
//   - rst is synchronous and active-high. It never touches the memory array.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   we        in   write enable (qualified by ce)
//   ce        in   chip enable
//   addr      in   [ADDR_WIDTH-1:0] byte address
//   data_in   in   [DATA_WIDTH-1:0] write data
//   data_out  out  [DATA_WIDTH-1:0] registered read data
//   err       out  access error flag, present only with RAM_ACCESS_ERR_EN
//
// Optional feature
//   Define RAM_ACCESS_ERR_EN to add the registered err output. On an enabled
//   access, err is set to 1 when the address is misaligned or out of range.
// ---------------------------------------------------------------------------
module ram_module #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 16384
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
`ifdef RAM_ACCESS_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [DATA_WIDTH-1:0] mem_r [0:MEM_WORDS-1];
    logic [DATA_WIDTH-1:0] data_out_r;
    logic [DATA_WIDTH-1:0] data_nxt_s;
    logic [IDX_W-1:0]      word_idx_s;
    logic [MEM_AW-1:0]     mem_idx_s;
    logic                  in_range_s;
    logic                  wr_en_s;

    assign word_idx_s = addr[ADDR_WIDTH-1:2];
    // The array index is truncated. An out-of-range index is never used for a
    // write, and its read value is masked to zero below.
    assign mem_idx_s  = MEM_AW'(word_idx_s);
    assign in_range_s = (32'(word_idx_s) < 32'(MEM_WORDS));

    // Write qualification: rst has priority, then ce, then we. A write also needs an in-range index.
    always_comb begin
        wr_en_s = 1'b0;
        if (rst) begin
            wr_en_s = 1'b0;
        end else if (ce && we && in_range_s) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next read-register value, selected with the ce/range/we priority.
    always_comb begin
        data_nxt_s = {DATA_WIDTH{1'b0}};
        if (!ce) begin
            data_nxt_s = {DATA_WIDTH{1'b0}};
        end else if (!in_range_s) begin
            data_nxt_s = {DATA_WIDTH{1'b0}};
        end else if (we) begin
            data_nxt_s = data_in;
        end else begin
            data_nxt_s = mem_r[mem_idx_s];
        end
    end

    // Memory array write port. It has no reset, so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[mem_idx_s] <= data_in;
        end
    end

    // Registered read data with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r <= {DATA_WIDTH{1'b0}};
        end else begin
            data_out_r <= data_nxt_s;
        end
    end

    assign data_out = data_out_r;

`ifdef RAM_ACCESS_ERR_EN
    logic err_r;
    logic err_nxt_s;

    // Error flag for an enabled access that is misaligned or out of range.
    always_comb begin
        err_nxt_s = 1'b0;
        if (ce) begin
            err_nxt_s = (addr[1:0] != 2'b00) || !in_range_s;
        end else begin
            err_nxt_s = 1'b0;
        end
    end

    // Registered error flag with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_nxt_s;
        end
    end

    assign err = err_r;
`endif

endmodule

// File: tb/tb_ram_module.sv
// ---------------------------------------------------------------------------
// tb_ram_module
//   Scoreboard bench for ram_module, with MEM_WORDS overridden to 1024.
//   The stimulus task drives one edge per call and queues the hand-computed
//   data_out/err expected after that edge. An independent monitor pops one
//   entry per rising edge and compares it 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_ram_module;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MW = 1024;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          we;
    logic          ce;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
`ifdef RAM_ACCESS_ERR_EN
    logic          err;
`endif

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   step_no;

    ram_module #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_WORDS (MW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .ce      (ce),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out)
`ifdef RAM_ACCESS_ERR_EN
        ,
        .err     (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's inputs at the falling edge and queue the expected result.
    task automatic step(input logic r, input logic c, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] ed, input logic ee);
        exp_t e;
        @(negedge clk);
        rst     = r;
        ce      = c;
        we      = w;
        addr    = a;
        data_in = d;
        step_no = step_no + 1;
        e.idx   = step_no;
        e.data  = ed;
        e.err   = ee;
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks = checks + 1;
                if (data_out !== e.data) begin
                    errors = errors + 1;
                    $display("FAIL data_out step %0d: got 0x%08h expected 0x%08h",
                             e.idx, data_out, e.data);
                end
`ifdef RAM_ACCESS_ERR_EN
                checks = checks + 1;
                if (err !== e.err) begin
                    errors = errors + 1;
                    $display("FAIL err step %0d: got %b expected %b", e.idx, err, e.err);
                end
`endif
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        step_no = 0;
        rst     = 1'b1;
        ce      = 1'b0;
        we      = 1'b0;
        addr    = 16'h0000;
        data_in = 32'h0000_0000;

        //    rst   ce    we    addr      data_in        exp data       exp err
        // Reset clears the output register.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        // Seed word 4, then check that a reset with ce/we high does not write it.
        step(1'b0, 1'b1, 1'b1, 16'h0010, 32'h1111_1111, 32'h1111_1111, 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'h0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0000_0000, 32'h1111_1111, 1'b0);
        // Basic write-through and the read that follows it.
        step(1'b0, 1'b1, 1'b1, 16'h0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h0004, 32'h1234_5678, 32'h1234_5678, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0004, 32'h0000_0000, 32'h1234_5678, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        // ce=0 clears the output and blocks the write even with we=1.
        step(1'b0, 1'b0, 1'b1, 16'h0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        // Back-to-back writes, then read-back.
        step(1'b0, 1'b1, 1'b1, 16'h0008, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h000C, 32'h5555_5555, 32'h5555_5555, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0008, 32'h0000_0000, 32'hAAAA_AAAA, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h000C, 32'h0000_0000, 32'h5555_5555, 1'b0);
        // Out-of-range write (word 1024 would alias word 0 if truncated).
        step(1'b0, 1'b1, 1'b1, 16'h1000, 32'h0BAD_F00D, 32'h0000_0000, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h1000, 32'h0000_0000, 32'h0000_0000, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'hFFFC, 32'h0000_0000, 32'h0000_0000, 1'b1);
        // Misaligned accesses reach the containing word.
        step(1'b0, 1'b1, 1'b0, 16'h0002, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'h0007, 32'h0000_0000, 32'h1234_5678, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h000B, 32'h0102_0304, 32'h0102_0304, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'h0008, 32'h0000_0000, 32'h0102_0304, 1'b0);
        // Last implemented word.
        step(1'b0, 1'b1, 1'b1, 16'h0FFC, 32'h7E7E_7E7E, 32'h7E7E_7E7E, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0FFC, 32'h0000_0000, 32'h7E7E_7E7E, 1'b0);
        // A misaligned access with ce=0 flags no error. Reset clears err.
        step(1'b0, 1'b0, 1'b0, 16'h0002, 32'h0000_0000, 32'h0000_0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h1002, 32'h0000_0000, 32'h0000_0000, 1'b1);
        step(1'b1, 1'b1, 1'b0, 16'h1002, 32'h0000_0000, 32'h0000_0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h000C, 32'h0000_0000, 32'h5555_5555, 1'b0);

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() > 0) begin
                @(posedge clk);
                #2;
            end
        end
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
